seq_detect_param: RTL and testbench



---
 rtl/seq_pkg.sv | 25 ++
 rtl/seq_shift_match.sv | 76 +++++++
 rtl/seq_detect_param.sv | 165 ++++++++++++++++
 tb/tb_seq_detect_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern detector:
//   - one-hot FSM state encoding (IDLE / SCAN / DONE)
//   - legal parameter range limits
//   - cnt_width(): bits needed to hold the values 0..n
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SCAN = 3'b010,
    ST_DONE = 3'b100
  } state_e;

  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 32;
  localparam int PAT_W_MIN  = 2;

  // Width able to represent every value from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// -----------------------------------------------------------------------------
// seq_shift_match
// Bit-serial window matcher. Keeps the last PAT_W-1 scanned bits (hist) and
// a saturating count of how many valid bits the history holds (fill). The
// incoming bit completes a PAT_W-bit window {hist, bit_in}; a hit is reported
// when that window is fully populated and equals the pattern.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear history and fill (start of a new scan)
//   en          consume bit_in this cycle
//   bit_in      current scanned bit
//   pat         pattern, bit PAT_W-1 is the earliest bit in time
//   ovl         1 = overlapping hits, 0 = restart fill after each hit
//   hit         combinational: window {hist, bit_in} is full and matches pat
// -----------------------------------------------------------------------------
module seq_shift_match
  import seq_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic             ovl,
  output logic             hit
);

  localparam int FILL_W = cnt_width(PAT_W);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  window;

  assign window = {hist_q, bit_in};

  // fill_q >= PAT_W-1 is the same as "fill+1 >= PAT_W": with the incoming bit
  // the window holds PAT_W valid bits.
  assign hit = (fill_q >= FILL_W'(PAT_W - 1)) && (window == pat);

  always_comb begin
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = window[PAT_W-2:0];
      // Non-overlapping mode forgets the history by emptying fill; the stale
      // hist bits are harmless because no hit is possible until fill refills.
      if (hit && !ovl) begin
        fill_d = '0;
      end else if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial pattern detector for switch words. A start pulse snapshots data,
// pattern and overlap mode, then the word is scanned MSB-first, one bit per
// clock. Hits are counted and the scan index of the first hit is recorded.
// Changing data during a scan aborts it; start at any time restarts.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse, begins (or restarts) a scan
//   data        word to scan, bit DATA_W-1 scanned first
//   pattern     pattern, bit PAT_W-1 earliest in time
//   overlap     1 = overlapping hits, 0 = history cleared after each hit
//   busy        high while scanning
//   done        one-cycle pulse after a scan completes normally
//   match       at least one hit in the current / last completed scan
//   match_cnt   number of hits
//   first_pos   scan index (0 = MSB) of the last bit of the first hit
// -----------------------------------------------------------------------------
module seq_detect_param
  import seq_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int PAT_W  = 4,
  localparam int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      PAT_W < PAT_W_MIN || PAT_W > DATA_W) begin : g_bad_params
    $fatal(1, "seq_detect_param: DATA_W must be 2..32 and PAT_W 2..DATA_W");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              done_q, done_d;

  logic              sm_clr, sm_en, sm_hit;
  logic [DATA_W-1:0] scan_word;
  logic              scan_bit;

  // Shifting left by idx keeps the current bit at the MSB without an
  // index that could fall out of range once idx has run past the word.
  assign scan_word = data_q << idx_q;
  assign scan_bit  = scan_word[DATA_W-1];

  seq_shift_match #(
    .PAT_W (PAT_W)
  ) u_shift_match (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sm_clr),
    .en     (sm_en),
    .bit_in (scan_bit),
    .pat    (pat_q),
    .ovl    (ovl_q),
    .hit    (sm_hit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      idx_q   <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    idx_d   = idx_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    sm_clr  = 1'b0;
    sm_en   = 1'b0;

    if (start) begin
      // Start wins over everything, including a simultaneous data change.
      state_d = ST_SCAN;
      data_d  = data;
      pat_d   = pattern;
      ovl_d   = overlap;
      idx_d   = '0;
      match_d = 1'b0;
      cnt_d   = '0;
      first_d = '0;
      sm_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_SCAN: begin
          if (data != data_q) begin
            // Switches moved under us: abandon the scan and its results.
            state_d = ST_IDLE;
            match_d = 1'b0;
            cnt_d   = '0;
            first_d = '0;
          end else begin
            sm_en = 1'b1;
            if (sm_hit) begin
              match_d = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              if (cnt_q == '0) first_d = idx_q;
            end
            idx_d = idx_q + CNT_W'(1);
            if (idx_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs. done is registered from the DONE state, so it appears
  // DATA_W+1 clocks after the edge that sampled start.
  always_comb begin
    busy   = (state_q == ST_SCAN);
    done_d = (state_q == ST_DONE);
  end

  assign done      = done_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign first_pos = first_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic clk;
  logic rst_n;

  // DUT A: DATA_W=8, PAT_W=4
  logic       start8;
  logic [7:0] data8;
  logic [3:0] pat8;
  logic       ovl8;
  logic       busy8, done8, match8;
  logic [3:0] cnt8, first8;

  // DUT B: DATA_W=16, PAT_W=3
  logic        start16;
  logic [15:0] data16;
  logic [2:0]  pat16;
  logic        ovl16;
  logic        busy16, done16, match16;
  logic [4:0]  cnt16, first16;

  int n_checks = 0;
  int n_pass   = 0;

  seq_detect_param #(.DATA_W(8), .PAT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .data(data8), .pattern(pat8),
    .overlap(ovl8), .busy(busy8), .done(done8), .match(match8),
    .match_cnt(cnt8), .first_pos(first8)
  );

  seq_detect_param #(.DATA_W(16), .PAT_W(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .data(data16), .pattern(pat16),
    .overlap(ovl16), .busy(busy16), .done(done16), .match(match16),
    .match_cnt(cnt16), .first_pos(first16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: slide a PAT_W window over the word in scan order; in
  // non-overlapping mode a hit may only end PAT_W or more bits after the last.
  function automatic void model(input logic [31:0] d, input int dw,
                                input logic [31:0] p, input int pw,
                                input bit ovl, output int cnt, output int first);
    int last_end;
    bit eq;
    last_end = -1000;
    cnt = 0;
    first = 0;
    for (int e = pw - 1; e < dw; e++) begin
      eq = 1'b1;
      for (int j = 0; j < pw; j++)
        if (d[dw - 1 - (e - pw + 1 + j)] != p[pw - 1 - j]) eq = 1'b0;
      if (eq && (ovl || (e - last_end) >= pw)) begin
        if (cnt == 0) first = e;
        cnt++;
        last_end = e;
      end
    end
  endfunction

  task automatic start_pulse8(input logic [7:0] d, input logic [3:0] p, input bit o);
    data8 = d; pat8 = p; ovl8 = o; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input bit scramble, output int lat);
    lat = 0;
    do begin
      if (scramble) begin
        pat8 = 4'($urandom);
        ovl8 = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end while (!done8 && lat < 40);
  endtask

  task automatic start_pulse16(input logic [15:0] d, input logic [2:0] p, input bit o);
    data16 = d; pat16 = p; ovl16 = o; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done16 && lat < 60);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] pat;
    bit         ovl;
    int         exp_cnt;
    int         exp_first;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, ecnt, efirst, seen;
    logic [7:0]  rd;
    logic [3:0]  rp;
    logic [15:0] rd16;
    logic [2:0]  rp16;
    bit          ro;

    tbl[0] = '{8'b1001_0010, 4'b1001, 1'b1, 2, 3};
    tbl[1] = '{8'b1001_0010, 4'b1001, 1'b0, 1, 3};
    tbl[2] = '{8'h00,        4'b1001, 1'b1, 0, 0};
    tbl[3] = '{8'hFF,        4'b1111, 1'b1, 5, 3};
    tbl[4] = '{8'hFF,        4'b1111, 1'b0, 2, 3};
    tbl[5] = '{8'b1010_1010, 4'b1010, 1'b1, 3, 3};
    tbl[6] = '{8'b1010_1010, 4'b1010, 1'b0, 2, 3};
    tbl[7] = '{8'b0000_1001, 4'b1001, 1'b0, 1, 7};

    rst_n = 1'b0;
    start8 = 1'b0; data8 = '0; pat8 = '0; ovl8 = 1'b0;
    start16 = 1'b0; data16 = '0; pat16 = '0; ovl16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",  int'(busy8),  0);
    check("reset_done",  int'(done8),  0);
    check("reset_match", int'(match8), 0);
    check("reset_cnt",   int'(cnt8),   0);
    check("reset_first", int'(first8), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven scans on the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      start_pulse8(tbl[i].data, tbl[i].pat, tbl[i].ovl);
      check($sformatf("tbl%0d_busy", i), int'(busy8), 1);
      wait_done8(1'b0, lat);
      check($sformatf("tbl%0d_latency", i), lat, 9);
      check($sformatf("tbl%0d_match", i), int'(match8), int'(tbl[i].exp_cnt > 0));
      check($sformatf("tbl%0d_cnt", i), int'(cnt8), tbl[i].exp_cnt);
      check($sformatf("tbl%0d_first", i), int'(first8), tbl[i].exp_first);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), int'(done8), 0);
      check($sformatf("tbl%0d_cnt_hold", i), int'(cnt8), tbl[i].exp_cnt);
    end

    // Abort: data changes three cycles into the scan.
    start_pulse8(8'b1001_1001, 4'b1001, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    data8 = 8'h01;
    check("abort_busy_before", int'(busy8), 1);
    @(posedge clk); #1;
    check("abort_busy_after", int'(busy8), 0);
    check("abort_match", int'(match8), 0);
    check("abort_cnt", int'(cnt8), 0);
    check("abort_first", int'(first8), 0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) seen = 1; end
    check("abort_no_done", seen, 0);

    // Restart at scan cycle 5 with new data in the same cycle.
    start_pulse8(8'b1001_0010, 4'b1001, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("restart_pre_match", int'(match8), 1);
    start_pulse8(8'b0000_1001, 4'b1001, 1'b0);
    check("restart_busy", int'(busy8), 1);
    check("restart_cleared_match", int'(match8), 0);
    check("restart_cleared_cnt", int'(cnt8), 0);
    wait_done8(1'b0, lat);
    check("restart_latency", lat, 9);
    check("restart_cnt", int'(cnt8), 1);
    check("restart_first", int'(first8), 7);

    // Reset in the middle of a third scan.
    start_pulse8(8'b1001_0110, 4'b1001, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_pre_match", int'(match8), 1);
    check("midrst_pre_first", int'(first8), 3);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy8), 0);
    check("midrst_match", int'(match8), 0);
    check("midrst_cnt", int'(cnt8), 0);
    check("midrst_first", int'(first8), 0);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done8) seen = 1; end
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) seen = 1; end
    check("midrst_no_done", seen, 0);

    // 16-bit instance: 0xAAAA / 101 in both modes.
    start_pulse16(16'hAAAA, 3'b101, 1'b1);
    wait_done16(lat);
    check("w16_ovl_latency", lat, 17);
    check("w16_ovl_cnt", int'(cnt16), 7);
    check("w16_ovl_first", int'(first16), 2);
    check("w16_ovl_match", int'(match16), 1);
    @(posedge clk); #1;
    start_pulse16(16'hAAAA, 3'b101, 1'b0);
    wait_done16(lat);
    check("w16_novl_latency", lat, 17);
    check("w16_novl_cnt", int'(cnt16), 4);
    check("w16_novl_first", int'(first16), 2);

    // Random scans against the reference model; pattern/overlap wiggle
    // during the scan on the 8-bit instance and must be ignored.
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      rp = 4'($urandom);
      ro = 1'($urandom);
      if (i % 4 == 0) rd = {rp, 4'($urandom)};
      model(32'(rd), 8, 32'(rp), 4, ro, ecnt, efirst);
      start_pulse8(rd, rp, ro);
      wait_done8(1'b1, lat);
      check($sformatf("rnd8_%0d_latency", i), lat, 9);
      check($sformatf("rnd8_%0d_cnt", i), int'(cnt8), ecnt);
      check($sformatf("rnd8_%0d_first", i), int'(first8), efirst);
      check($sformatf("rnd8_%0d_match", i), int'(match8), int'(ecnt > 0));
    end

    for (int i = 0; i < 12; i++) begin
      rd16 = 16'($urandom);
      rp16 = 3'($urandom);
      ro   = 1'($urandom);
      model(32'(rd16), 16, 32'(rp16), 3, ro, ecnt, efirst);
      start_pulse16(rd16, rp16, ro);
      wait_done16(lat);
      check($sformatf("rnd16_%0d_latency", i), lat, 17);
      check($sformatf("rnd16_%0d_cnt", i), int'(cnt16), ecnt);
      check($sformatf("rnd16_%0d_first", i), int'(first16), efirst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
